// File: rtl/pio_ram_arb_pkg.sv
// Shared types and helpers for the PIO RAM read-channel arbiter.
package pio_ram_arb_pkg;

  localparam int unsigned DefNReq           = 4;
  localparam int unsigned DefAddrBits       = 16;
  localparam int unsigned DefDataBits       = 16;
  localparam int unsigned DefMaxOutstanding = 4;

  // Widest requester set the picker supports.
  localparam int unsigned MaxReq  = 8;
  localparam int unsigned IdxMaxW = 3;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  typedef struct packed {
    logic               found;
    logic [IdxMaxW-1:0] idx;
  } rr_pick_t;

  // First valid requester searching upward from last+1, wrapping at n_req.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0]  valid,
                                       input logic [IdxMaxW-1:0] last,
                                       input int unsigned        n_req);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      idx = (32'(last) + k) % n_req;
      if (k <= n_req && !r.found && valid[idx[IdxMaxW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[IdxMaxW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pio_ram_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding read.
module pio_ram_tag_fifo #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         head,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == (AW+1)'(Depth));
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem_q[rptr_q];
  assign count   = count_q;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (push_en) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_en) rptr_q <= rptr_q + 1'b1;
      if (push_en && !pop_en)      count_q <= count_q + 1'b1;
      else if (!push_en && pop_en) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/pio_ram_read_arbiter.sv
// Round-robin arbiter sharing the PIO RAM read channel; replies routed by tag FIFO.
module pio_ram_read_arbiter
  import pio_ram_arb_pkg::*;
#(
  parameter int unsigned N_REQ           = DefNReq,
  parameter int unsigned ADDR_BITS       = DefAddrBits,
  parameter int unsigned DATA_BITS       = DefDataBits,
  parameter int unsigned MAX_OUTSTANDING = DefMaxOutstanding
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ADDR_BITS-1:0] req_addr,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           resp_valid,
  output logic [DATA_BITS-1:0]       resp_data,
  output logic                       port_valid,
  output logic [ADDR_BITS-1:0]       port_addr,
  input  logic                       port_ready,
  input  logic                       port_resp_valid,
  input  logic [DATA_BITS-1:0]       port_resp_data,
  output logic                       err_orphan
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_t          state_q;
  logic [IdxW-1:0]     lock_idx_q, last_grant_q;
  logic [N_REQ-1:0]    resp_valid_q;
  logic [DATA_BITS-1:0] resp_data_q;
  logic                err_orphan_q;

  logic [MaxReq-1:0]   valid_ext;
  logic [IdxMaxW-1:0]  last_ext;
  rr_pick_t            pick;
  logic [IdxW-1:0]     sel, head;
  logic                accept, pop, full, empty;
  logic [CntW-1:0]     count;

  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = req_valid;
    last_ext               = '0;
    last_ext[IdxW-1:0]     = last_grant_q;
    pick                   = rr_pick(valid_ext, last_ext, N_REQ);
    sel = (state_q == ARB_LOCKED) ? lock_idx_q : pick.idx[IdxW-1:0];
    // Gated by rst_n so the command drops the instant reset asserts.
    port_valid = rst_n && ((state_q == ARB_LOCKED) || (pick.found && !full));
    port_addr  = req_addr[32'(sel) * ADDR_BITS +: ADDR_BITS];
    accept     = port_valid && port_ready;
    req_ready  = '0;
    if (accept) req_ready[sel] = 1'b1;
  end

  assign pop        = port_resp_valid && !empty;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign err_orphan = err_orphan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      lock_idx_q   <= '0;
      last_grant_q <= IdxW'(N_REQ - 1);
    end else if (accept) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= sel;
    end else if (state_q == ARB_IDLE && port_valid) begin
      state_q    <= ARB_LOCKED;
      lock_idx_q <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (pop) begin
        resp_valid_q[head] <= 1'b1;
        resp_data_q        <= port_resp_data;
      end
      if (port_resp_valid && empty) err_orphan_q <= 1'b1;
    end
  end

  pio_ram_tag_fifo #(
    .Width (IdxW),
    .Depth (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (sel),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  count_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
                                  count <= CntW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_pio_ram_read_arbiter.sv
// Directed self-checking bench for pio_ram_read_arbiter (default parameters).
module tb_pio_ram_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [15:0] resp_data;
  logic        port_valid;
  logic [15:0] port_addr;
  logic        port_ready;
  logic        port_resp_valid;
  logic [15:0] port_resp_data;
  logic        err_orphan;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pio_ram_read_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .port_valid      (port_valid),
    .port_addr       (port_addr),
    .port_ready      (port_ready),
    .port_resp_valid (port_resp_valid),
    .port_resp_data  (port_resp_data),
    .err_orphan      (err_orphan)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; port_ready = 1'b0;
    port_resp_valid = 1'b0; port_resp_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1111; req_addr = 64'h4444_3333_2222_1111; port_ready = 1'b1;
    port_resp_valid = 1'b0; port_resp_data = '0;
    #1;
    vec_cnt++; if (port_valid !== 1'b0) begin err_cnt++;
      $display("FAIL reset_port_valid got %b want 0", port_valid); end
    vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++;
      $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    @(posedge clk); #1;
    vec_cnt++; if (resp_valid !== 4'b0000 || resp_data !== 16'h0 || err_orphan !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_regs got rv=%b rd=%h eo=%b want 0/0/0", resp_valid, resp_data,
               err_orphan);
    end
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100; req_addr[2*16 +: 16] = 16'h1234; port_ready = 1'b1;
    #1;
    vec_cnt++; if (port_valid !== 1'b1 || port_addr !== 16'h1234) begin err_cnt++;
      $display("FAIL single_cmd got v=%b a=%h want 1/1234", port_valid, port_addr); end
    vec_cnt++; if (req_ready !== 4'b0100) begin err_cnt++;
      $display("FAIL single_ready got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (21) @(negedge clk);
    port_resp_valid = 1'b1; port_resp_data = 16'hBEEF;
    @(posedge clk); #1;
    vec_cnt++; if (resp_valid !== 4'b0100 || resp_data !== 16'hBEEF) begin err_cnt++;
      $display("FAIL single_resp got rv=%b rd=%h want 0100/beef", resp_valid, resp_data); end
    @(negedge clk); port_resp_valid = 1'b0;
    @(posedge clk); #1;
    vec_cnt++; if (resp_valid !== 4'b0000 || err_orphan !== 1'b0) begin err_cnt++;
      $display("FAIL single_strobe got rv=%b eo=%b want 0000/0", resp_valid, err_orphan); end
  endtask

  task automatic test_round_robin();
    logic [3:0] prev;
    logic [3:0] exp;
    do_reset();
    req_addr = 64'hD003_D002_D001_D000;
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 4'b1111; port_ready = 1'b1;
      // Reply every cycle after the first so the FIFO never fills.
      port_resp_valid = (i > 0); port_resp_data = 16'(16'h100 + i);
      exp = 4'b0001 << (i % 4);
      #1;
      vec_cnt++; if (req_ready !== exp || port_addr !== 16'(16'hD000 + (i % 4))) begin
        err_cnt++;
        $display("FAIL rr_grant%0d got rdy=%b a=%h want %b/%h", i, req_ready, port_addr, exp,
                 16'(16'hD000 + (i % 4)));
      end
      @(posedge clk); #1;
      if (i > 0) begin
        vec_cnt++; if (resp_valid !== prev || resp_data !== 16'(16'h100 + i)) begin
          err_cnt++;
          $display("FAIL rr_resp%0d got rv=%b rd=%h want %b/%h", i, resp_valid, resp_data,
                   prev, 16'(16'h100 + i));
        end
      end
      prev = exp;
    end
    vec_cnt++; if (err_orphan !== 1'b0) begin err_cnt++;
      $display("FAIL rr_orphan got %b want 0", err_orphan); end
  endtask

  task automatic test_lock();
    do_reset();
    @(negedge clk);
    req_addr[0 +: 16] = 16'h0AAA; req_addr[16 +: 16] = 16'h1111;
    req_valid = 4'b0010; port_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vec_cnt++; if (port_valid !== 1'b1 || port_addr !== 16'h1111 || req_ready !== 4'b0)
      begin
        err_cnt++;
        $display("FAIL lock_hold%0d got v=%b a=%h rdy=%b want 1/1111/0000", i, port_valid,
                 port_addr, req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0011;
    end
    port_ready = 1'b1;
    #1;
    vec_cnt++; if (req_ready !== 4'b0010 || port_addr !== 16'h1111) begin err_cnt++;
      $display("FAIL lock_accept got rdy=%b a=%h want 0010/1111", req_ready, port_addr); end
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    vec_cnt++; if (req_ready !== 4'b0001 || port_addr !== 16'h0AAA) begin err_cnt++;
      $display("FAIL lock_next got rdy=%b a=%h want 0001/0aaa", req_ready, port_addr); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_full();
    do_reset();
    req_addr[0 +: 16] = 16'h00F0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 4'b0001; port_ready = 1'b1;
      #1;
      vec_cnt++; if (req_ready !== 4'b0001) begin err_cnt++;
        $display("FAIL full_fill%0d got %b want 0001", i, req_ready); end
    end
    @(negedge clk); #1;
    vec_cnt++; if (port_valid !== 1'b0 || req_ready !== 4'b0) begin err_cnt++;
      $display("FAIL full_block got v=%b rdy=%b want 0/0000", port_valid, req_ready); end
    @(negedge clk);
    port_resp_valid = 1'b1; port_resp_data = 16'h0055;
    #1;
    vec_cnt++; if (port_valid !== 1'b0) begin err_cnt++;
      $display("FAIL full_pop_cycle got v=%b want 0", port_valid); end
    @(negedge clk);
    port_resp_valid = 1'b0;
    #1;
    vec_cnt++; if (port_valid !== 1'b1 || req_ready !== 4'b0001) begin err_cnt++;
      $display("FAIL full_resume got v=%b rdy=%b want 1/0001", port_valid, req_ready); end
    vec_cnt++; if (resp_valid !== 4'b0001 || resp_data !== 16'h0055) begin err_cnt++;
      $display("FAIL full_resp got rv=%b rd=%h want 0001/0055", resp_valid, resp_data); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_ordering();
    logic [3:0]  order [3];
    logic [15:0] data  [3];
    order[0] = 4'b1000; order[1] = 4'b0001; order[2] = 4'b1000;
    data[0] = 16'h000A; data[1] = 16'h000B; data[2] = 16'h000C;
    do_reset();
    req_addr = 64'h3000_0000_0000_0F00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = order[i]; port_ready = 1'b1;
      #1;
      vec_cnt++; if (req_ready !== order[i]) begin err_cnt++;
        $display("FAIL order_issue%0d got %b want %b", i, req_ready, order[i]); end
    end
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      port_resp_valid = 1'b1; port_resp_data = data[i];
      @(posedge clk); #1;
      vec_cnt++; if (resp_valid !== order[i] || resp_data !== data[i]) begin err_cnt++;
        $display("FAIL order_resp%0d got rv=%b rd=%h want %b/%h", i, resp_valid, resp_data,
                 order[i], data[i]);
      end
    end
    @(negedge clk);
    port_resp_valid = 1'b0;
    vec_cnt++; if (err_orphan !== 1'b0) begin err_cnt++;
      $display("FAIL order_orphan got %b want 0", err_orphan); end
  endtask

  task automatic test_orphan_reset();
    do_reset();
    @(negedge clk);
    port_resp_valid = 1'b1; port_resp_data = 16'h0077;
    @(posedge clk); #1;
    vec_cnt++; if (err_orphan !== 1'b1 || resp_valid !== 4'b0) begin err_cnt++;
      $display("FAIL orphan_set got eo=%b rv=%b want 1/0000", err_orphan, resp_valid); end
    @(negedge clk);
    port_resp_valid = 1'b0;
    req_addr[2*16 +: 16] = 16'h2222; req_valid = 4'b0100; port_ready = 1'b0;
    @(negedge clk); #1;
    vec_cnt++; if (port_valid !== 1'b1 || port_addr !== 16'h2222) begin err_cnt++;
      $display("FAIL orphan_locked got v=%b a=%h want 1/2222", port_valid, port_addr); end
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (port_valid !== 1'b0 || req_ready !== 4'b0 || err_orphan !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_lock got v=%b rdy=%b eo=%b want 0/0000/0", port_valid,
               req_ready, err_orphan);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    port_resp_valid = 1'b1; port_resp_data = 16'h0099;
    @(posedge clk); #1;
    vec_cnt++; if (err_orphan !== 1'b1 || resp_valid !== 4'b0) begin err_cnt++;
      $display("FAIL orphan_after_reset got eo=%b rv=%b want 1/0000", err_orphan, resp_valid);
    end
    @(negedge clk);
    port_resp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; port_ready = 1'b0;
    port_resp_valid = 1'b0; port_resp_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_full();
    test_ordering();
    test_orphan_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
